// File: rtl/rs_sched_if.sv
// Handshake bundle between the syndrome producer, the shared RS resolver and the
// ECC correction consumer. master is the scheduler's view, slave the surroundings'.
interface rs_sched_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [31:0]      synIn;
  logic [TAG_W-1:0] synTag;
  logic             synValid;
  logic             synAccept;
  logic [7:0]       si0;
  logic [7:0]       si1;
  logic [7:0]       si2;
  logic [7:0]       si3;
  logic             synReady;
  logic [33:0]      RSresults;
  logic             RSdone;
  logic             resValid;
  logic [33:0]      resData;
  logic [TAG_W-1:0] resTag;
  logic             resAck;
  logic             timeoutErr;
  logic [LVL_W-1:0] fifoLevel;

  modport master (
    input  synIn, synTag, synValid, RSresults, RSdone, resAck,
    output synAccept, si0, si1, si2, si3, synReady, resValid, resData, resTag,
           timeoutErr, fifoLevel
  );

  modport slave (
    output synIn, synTag, synValid, RSresults, RSdone, resAck,
    input  synAccept, si0, si1, si2, si3, synReady, resValid, resData, resTag,
           timeoutErr, fifoLevel
  );
endinterface

// File: rtl/rs_sched.sv
// Sequences tagged syndrome sets through the shared Reed-Solomon resolver and
// returns each tagged result over a valid/ack handshake, flagging resolver hangs.
module rs_sched #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic          clk,
  input  logic          reset,
  rs_sched_if.master    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HANG = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [31:0]      syn_mem_r [DEPTH];
  logic [TAG_W-1:0] tag_mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [TAG_W-1:0] tag_hold_r;
  logic [31:0]      si_r;
  logic [31:0]      si_out_s;
  logic             res_valid_r;
  logic [33:0]      res_data_r;
  logic [TAG_W-1:0] res_tag_r;
  logic             timeout_err_r;
  logic             accept_s;
  logic             push_s;
  logic             slot_free_s;
  logic             issue_s;
  logic             capture_s;
  logic             hang_s;

  assign accept_s    = (level_r != LVL_W'(DEPTH));
  assign push_s      = bus.synValid && accept_s;
  assign slot_free_s = !res_valid_r || bus.resAck;
  assign cnt_inc_s   = cnt_r + CNT_W'(1);

  // The resolver samples synReady and si together at the end of the issue cycle,
  // so the FIFO head is shown directly then and held from si_r afterwards.
  assign si_out_s = issue_s ? syn_mem_r[rd_ptr_r] : si_r;

  assign bus.synAccept  = accept_s;
  assign bus.synReady   = issue_s;
  assign bus.si0        = si_out_s[7:0];
  assign bus.si1        = si_out_s[15:8];
  assign bus.si2        = si_out_s[23:16];
  assign bus.si3        = si_out_s[31:24];
  assign bus.resValid   = res_valid_r;
  assign bus.resData    = res_data_r;
  assign bus.resTag     = res_tag_r;
  assign bus.timeoutErr = timeout_err_r;
  assign bus.fifoLevel  = level_r;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-cycle strobes: issue, normal capture, hang capture.
  always_comb begin
    state_s   = state_r;
    issue_s   = 1'b0;
    capture_s = 1'b0;
    hang_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((level_r != LVL_W'(0)) && bus.RSdone && slot_free_s) begin
          issue_s = 1'b1;
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // An all-zero set leaves the resolver in standby, so RSdone may already be high here.
        if (bus.RSdone) begin
          capture_s = 1'b1;
          state_s   = ST_IDLE;
        end else if (cnt_inc_s == CNT_W'(TIMEOUT)) begin
          hang_s  = 1'b1;
          state_s = ST_HANG;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HANG: begin
        if (bus.RSdone) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HANG;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FIFO storage; contents are only meaningful below the level, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      syn_mem_r[wr_ptr_r] <= bus.synIn;
      tag_mem_r[wr_ptr_r] <= bus.synTag;
    end
  end

  // FIFO pointers and occupancy; acceptance uses the registered level only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, issue_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Issued set, its tag and the WAIT cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      si_r       <= 32'h0;
      tag_hold_r <= '0;
      cnt_r      <= '0;
    end else if (issue_s) begin
      si_r       <= syn_mem_r[rd_ptr_r];
      tag_hold_r <= tag_mem_r[rd_ptr_r];
      cnt_r      <= '0;
    end else if (state_r == ST_WAIT) begin
      cnt_r <= cnt_inc_s;
    end
  end

  // Result slot; a hang reports PSW=3 so the consumer treats the sector as uncorrectable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid_r   <= 1'b0;
      res_data_r    <= 34'h0;
      res_tag_r     <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      if (capture_s) begin
        res_valid_r <= 1'b1;
        res_data_r  <= bus.RSresults;
        res_tag_r   <= tag_hold_r;
      end else if (hang_s) begin
        res_valid_r <= 1'b1;
        res_data_r  <= {2'b11, 32'h0};
        res_tag_r   <= tag_hold_r;
      end else if (bus.resAck) begin
        res_valid_r <= 1'b0;
      end
      if (hang_s) begin
        timeout_err_r <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rs_sched.sv
// Directed bench for rs_sched: the test tasks play producer, resolver and consumer.
module tb_rs_sched;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  rs_sched_if #(.DEPTH(4), .TAG_W(4)) bus ();

  rs_sched #(.DEPTH(4), .TAG_W(4), .TIMEOUT(31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] data, input logic [3:0] tag);
    bus.synValid = 1'b1;
    bus.synIn    = data;
    bus.synTag   = tag;
    step();
    bus.synValid = 1'b0;
  endtask

  task automatic ack_result();
    bus.resAck = 1'b1;
    step();
    bus.resAck = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++;
    if (bus.synAccept !== 1'b1 || bus.synReady !== 1'b0 || bus.resValid !== 1'b0)
      $display("FAIL reset_ctl: accept=%0b ready=%0b valid=%0b exp 1/0/0", bus.synAccept, bus.synReady, bus.resValid);
    else pass_cnt++;
    total_cnt++;
    if (bus.resData !== 34'h0 || bus.resTag !== 4'h0 || bus.fifoLevel !== 3'd0 || bus.timeoutErr !== 1'b0)
      $display("FAIL reset_data: data=%0h tag=%0h level=%0d terr=%0b exp all 0", bus.resData, bus.resTag, bus.fifoLevel, bus.timeoutErr);
    else pass_cnt++;
    total_cnt++;
    if ({bus.si3, bus.si2, bus.si1, bus.si0} !== 32'h0)
      $display("FAIL reset_si: got=%0h exp=0", {bus.si3, bus.si2, bus.si1, bus.si0});
    else pass_cnt++;
  endtask

  task automatic test_zero_syndrome();
    push(32'h0000_0000, 4'd3);
    #1;
    total_cnt++;
    if (bus.synReady !== 1'b1) $display("FAIL zero_issue: synReady=%0b exp=1", bus.synReady);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.synReady !== 1'b0 || bus.resValid !== 1'b0)
      $display("FAIL zero_wait: synReady=%0b resValid=%0b exp 0/0", bus.synReady, bus.resValid);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.resValid !== 1'b1 || bus.resData[33:32] !== 2'b00 || bus.resTag !== 4'd3)
      $display("FAIL zero_result: valid=%0b psw=%0d tag=%0d exp 1/0/3", bus.resValid, bus.resData[33:32], bus.resTag);
    else pass_cnt++;
    ack_result();
    total_cnt++;
    if (bus.resValid !== 1'b0) $display("FAIL zero_ack: resValid=%0b exp=0", bus.resValid);
    else pass_cnt++;
  endtask

  task automatic test_nonzero();
    logic bad;
    bad = 1'b0;
    push(32'h1A2B_3C4D, 4'd5);
    #1;
    total_cnt++;
    if (bus.synReady !== 1'b1 || bus.si0 !== 8'h4D || bus.si3 !== 8'h1A)
      $display("FAIL nz_issue: ready=%0b si0=%0h si3=%0h exp 1/4d/1a", bus.synReady, bus.si0, bus.si3);
    else pass_cnt++;
    step();
    bus.RSdone = 1'b0;
    for (int i = 0; i < 21; i++) begin
      if (bus.si0 !== 8'h4D || bus.si2 !== 8'h2B || bus.synReady !== 1'b0 || bus.resValid !== 1'b0) bad = 1'b1;
      step();
    end
    bus.RSdone    = 1'b1;
    bus.RSresults = 34'h2_1122_3344;
    total_cnt++;
    if (bad !== 1'b0 || bus.si0 !== 8'h4D) $display("FAIL nz_si_hold: disturbed=%0b si0=%0h exp 0/4d", bad, bus.si0);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.resValid !== 1'b1 || bus.resData !== 34'h2_1122_3344 || bus.resTag !== 4'd5)
      $display("FAIL nz_result: valid=%0b data=%0h tag=%0d exp 1/211223344/5", bus.resValid, bus.resData, bus.resTag);
    else pass_cnt++;
    ack_result();
    bus.RSresults = 34'h0;
  endtask

  task automatic test_fifo_full();
    int n;
    bus.RSdone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.synValid = 1'b1;
      bus.synIn    = 32'h10 + 32'(i);
      bus.synTag   = 4'(i);
      step();
    end
    bus.synIn  = 32'h14;
    bus.synTag = 4'd4;
    #1;
    total_cnt++;
    if (bus.fifoLevel !== 3'd4 || bus.synAccept !== 1'b0)
      $display("FAIL full_level: level=%0d accept=%0b exp 4/0", bus.fifoLevel, bus.synAccept);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.fifoLevel !== 3'd4) $display("FAIL full_no_overflow: level=%0d exp=4", bus.fifoLevel);
    else pass_cnt++;
    bus.RSdone = 1'b1;
    #1;
    total_cnt++;
    if (bus.synReady !== 1'b1 || bus.si0 !== 8'h10) $display("FAIL full_head: ready=%0b si0=%0h exp 1/10", bus.synReady, bus.si0);
    else pass_cnt++;
    step();
    step();
    bus.synValid = 1'b0;
    total_cnt++;
    if (bus.fifoLevel !== 3'd4) $display("FAIL full_refill: level=%0d exp=4", bus.fifoLevel);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (bus.resValid !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      total_cnt++;
      if (bus.resValid !== 1'b1 || bus.resTag !== 4'(k))
        $display("FAIL full_order: valid=%0b tag=%0d exp 1/%0d", bus.resValid, bus.resTag, k);
      else pass_cnt++;
      ack_result();
    end
    total_cnt++;
    if (bus.fifoLevel !== 3'd0) $display("FAIL full_drain: level=%0d exp=0", bus.fifoLevel);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic bad;
    bad = 1'b0;
    bus.RSdone = 1'b0;
    push(32'h0000_0060, 4'd6);
    push(32'h0000_0070, 4'd7);
    bus.RSdone = 1'b1;
    #1;
    total_cnt++;
    if (bus.synReady !== 1'b1 || bus.fifoLevel !== 3'd2)
      $display("FAIL b2b_issue: ready=%0b level=%0d exp 1/2", bus.synReady, bus.fifoLevel);
    else pass_cnt++;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      if (bus.synReady !== 1'b0 || bus.resValid !== 1'b1 || bus.resTag !== 4'd6 || bus.fifoLevel !== 3'd1) bad = 1'b1;
      step();
    end
    total_cnt++;
    if (bad !== 1'b0) $display("FAIL b2b_hold: disturbed=%0b exp 0", bad);
    else pass_cnt++;
    bus.resAck = 1'b1;
    #1;
    total_cnt++;
    if (bus.synReady !== 1'b1 || bus.si0 !== 8'h70) $display("FAIL b2b_ack_issue: ready=%0b si0=%0h exp 1/70", bus.synReady, bus.si0);
    else pass_cnt++;
    step();
    bus.resAck = 1'b0;
    total_cnt++;
    if (bus.resValid !== 1'b0) $display("FAIL b2b_clear: resValid=%0b exp=0", bus.resValid);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.resValid !== 1'b1 || bus.resTag !== 4'd7) $display("FAIL b2b_second: valid=%0b tag=%0d exp 1/7", bus.resValid, bus.resTag);
    else pass_cnt++;
    ack_result();
  endtask

  task automatic test_timeout();
    push(32'h0000_0099, 4'd9);
    #1;
    total_cnt++;
    if (bus.synReady !== 1'b1) $display("FAIL to_issue: synReady=%0b exp=1", bus.synReady);
    else pass_cnt++;
    step();
    bus.RSdone = 1'b0;
    for (int i = 0; i < 30; i++) step();
    total_cnt++;
    if (bus.timeoutErr !== 1'b0 || bus.resValid !== 1'b0)
      $display("FAIL to_early: terr=%0b valid=%0b exp 0/0", bus.timeoutErr, bus.resValid);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.timeoutErr !== 1'b1 || bus.resValid !== 1'b1 || bus.resData !== 34'h3_0000_0000 || bus.resTag !== 4'd9)
      $display("FAIL to_capture: terr=%0b valid=%0b data=%0h tag=%0d exp 1/1/300000000/9", bus.timeoutErr, bus.resValid, bus.resData, bus.resTag);
    else pass_cnt++;
    push(32'h0000_0001, 4'd10);
    ack_result();
    total_cnt++;
    if (bus.fifoLevel !== 3'd1 || bus.synReady !== 1'b0 || bus.resValid !== 1'b0)
      $display("FAIL to_hang: level=%0d ready=%0b valid=%0b exp 1/0/0", bus.fifoLevel, bus.synReady, bus.resValid);
    else pass_cnt++;
    bus.RSdone = 1'b1;
    #1;
    total_cnt++;
    if (bus.synReady !== 1'b0) $display("FAIL to_hang_exit: synReady=%0b exp=0", bus.synReady);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.synReady !== 1'b1) $display("FAIL to_reissue: synReady=%0b exp=1", bus.synReady);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if (bus.resValid !== 1'b1 || bus.resTag !== 4'd10 || bus.timeoutErr !== 1'b1)
      $display("FAIL to_sticky: valid=%0b tag=%0d terr=%0b exp 1/10/1", bus.resValid, bus.resTag, bus.timeoutErr);
    else pass_cnt++;
    ack_result();
  endtask

  task automatic test_reset_mid_wait();
    push(32'h0000_0001, 4'd1);
    step();
    bus.RSdone = 1'b0;
    push(32'h0000_0002, 4'd2);
    push(32'h0000_0003, 4'd3);
    push(32'h0000_0004, 4'd4);
    total_cnt++;
    if (bus.fifoLevel !== 3'd3) $display("FAIL rst_pre: level=%0d exp=3", bus.fifoLevel);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    test_reset();
    step();
    total_cnt++;
    if (bus.fifoLevel !== 3'd0 || bus.synReady !== 1'b0 || bus.timeoutErr !== 1'b0)
      $display("FAIL rst_hold: level=%0d ready=%0b terr=%0b exp 0/0/0", bus.fifoLevel, bus.synReady, bus.timeoutErr);
    else pass_cnt++;
    reset      = 1'b1;
    bus.RSdone = 1'b1;
    push(32'hCAFE_0012, 4'd2);
    #1;
    total_cnt++;
    if (bus.synReady !== 1'b1 || bus.si0 !== 8'h12) $display("FAIL rst_resume_issue: ready=%0b si0=%0h exp 1/12", bus.synReady, bus.si0);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if (bus.resValid !== 1'b1 || bus.resTag !== 4'd2 || bus.resData !== 34'h0)
      $display("FAIL rst_resume_result: valid=%0b tag=%0d data=%0h exp 1/2/0", bus.resValid, bus.resTag, bus.resData);
    else pass_cnt++;
    ack_result();
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    reset         = 1'b0;
    bus.synIn     = 32'h0;
    bus.synTag    = 4'h0;
    bus.synValid  = 1'b0;
    bus.RSresults = 34'h0;
    bus.RSdone    = 1'b1;
    bus.resAck    = 1'b0;
    step();
    step();
    test_reset();
    reset = 1'b1;
    step();
    test_zero_syndrome();
    test_nonzero();
    test_fifo_full();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
